// File: rtl/masked_array_if.sv
// Request/response bundle for masked_array: write/read controls in, clear-sweep
// status and read data out.
interface masked_array_if #(
   parameter int s_index = 3,
   parameter int width   = 32,
   parameter int gran    = 8
);
   localparam int nlanes = width / gran;

   logic                read;
   logic                load;
   logic [s_index-1:0]  rindex;
   logic [s_index-1:0]  windex;
   logic [nlanes-1:0]   wmask;
   logic [width-1:0]    datain;
   logic                clear;
   logic                busy;
   logic                done;
   logic [width-1:0]    dataout;

   modport master (
      output read, load, rindex, windex, wmask, datain, clear,
      input  busy, done, dataout
   );

   modport slave (
      input  read, load, rindex, windex, wmask, datain, clear,
      output busy, done, dataout
   );
endinterface

// File: rtl/masked_array.sv
// Flop-based per-set array with lane-masked writes, write-first read bypass,
// optional registered read and a one-set-per-cycle hardware clear sweep.
module masked_array_lane #(
   parameter int gran = 8
) (
   input  logic            en_i,
   input  logic [gran-1:0] old_i,
   input  logic [gran-1:0] new_i,
   output logic [gran-1:0] merged_o
);
   assign merged_o = en_i ? new_i : old_i;
endmodule

module masked_array #(
   parameter int               s_index   = 3,
   parameter int               width     = 32,
   parameter int               gran      = 8,
   parameter int               reg_out   = 0,
   parameter logic [width-1:0] reset_val = '0
) (
   input  logic           clk,
   input  logic           rst_n,
   masked_array_if.slave  bus
);
   localparam int num_sets = 2 ** s_index;
   localparam int nlanes   = width / gran;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e                        state_q, state_d;
   logic [s_index-1:0]            cnt_q, cnt_d;
   logic                          done_q, done_d;
   logic [num_sets-1:0][width-1:0] data_q;
   logic [width-1:0]              wr_old, wr_merge, rd_val;
   logic                          busy, we;

   assign busy   = (state_q == SWEEP);
   // clear in IDLE takes priority over a same-cycle load
   assign we     = bus.load && !busy && !bus.clear;
   assign wr_old = data_q[bus.windex];

   for (genvar i = 0; i < nlanes; i++) begin : g_lane
      masked_array_lane #(.gran(gran)) u_lane (
         .en_i     (bus.wmask[i]),
         .old_i    (wr_old[i*gran +: gran]),
         .new_i    (bus.datain[i*gran +: gran]),
         .merged_o (wr_merge[i*gran +: gran])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.clear) begin
            state_d = SWEEP;
            cnt_d   = '0;
         end
         SWEEP: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    data_q <= {num_sets{reset_val}};
      else if (busy) data_q[cnt_q] <= reset_val;
      else if (we)   data_q[bus.windex] <= wr_merge;
   end

   // Bypass shows the merge even when a colliding clear drops the write.
   always_comb begin
      rd_val = data_q[bus.rindex];
      if (busy)                                     rd_val = reset_val;
      else if (bus.load && bus.rindex == bus.windex) rd_val = wr_merge;
   end

   if (reg_out != 0) begin : g_reg
      logic [width-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)        dout_q <= reset_val;
         else if (bus.read) dout_q <= rd_val;
      end
      assign bus.dataout = dout_q;
   end else begin : g_comb
      assign bus.dataout = rd_val;
   end

   assign bus.busy = busy;
   assign bus.done = done_q;
endmodule

// File: tb/tb_masked_array.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle they
// are due in; a negedge monitor compares and retires them.
module tb_masked_array;
   typedef struct {
      int          cyc;
      int          kind;   // 0 comb dataout, 1 reg dataout, 2 busy, 3 done
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   masked_array_if #(.s_index(3), .width(32), .gran(8)) bus0 ();
   masked_array_if #(.s_index(3), .width(32), .gran(8)) bus1 ();

   assign bus1.read   = bus0.read;
   assign bus1.load   = bus0.load;
   assign bus1.rindex = bus0.rindex;
   assign bus1.windex = bus0.windex;
   assign bus1.wmask  = bus0.wmask;
   assign bus1.datain = bus0.datain;
   assign bus1.clear  = bus0.clear;

   masked_array #(.s_index(3), .width(32), .gran(8), .reg_out(0), .reset_val(32'h0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   masked_array #(.s_index(3), .width(32), .gran(8), .reg_out(1), .reset_val(32'h0))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [31:0] act;
            case (sb[i].kind)
               0:       act = bus0.dataout;
               1:       act = bus1.dataout;
               2:       act = {31'b0, bus0.busy};
               default: act = {31'b0, bus0.done};
            endcase
            checks++;
            if (act !== sb[i].val) begin
               errors++;
               $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic rd, input logic ld, input logic [2:0] ri,
                      input logic [2:0] wi, input logic [3:0] wm,
                      input logic [31:0] di, input logic clr);
      bus0.read = rd; bus0.load = ld; bus0.rindex = ri; bus0.windex = wi;
      bus0.wmask = wm; bus0.datain = di; bus0.clear = clr;
   endtask

   task automatic expect_at(input int kind, input logic [31:0] v, input string nm,
                            input int dly);
      exp_t e;
      e.cyc = cyc + dly; e.kind = kind; e.val = v; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic wr(input logic [2:0] set, input logic [3:0] wm, input logic [31:0] d);
      drv(1'b0, 1'b1, 3'd0, set, wm, d, 1'b0);
   endtask

   // Combinational result this cycle, registered result one cycle later.
   task automatic read_chk(input logic [2:0] set, input logic [31:0] v, input string nm);
      drv(1'b1, 1'b0, set, 3'd0, 4'h0, 32'h0, 1'b0);
      expect_at(0, v, nm, 0);
      expect_at(1, v, {nm, "_r"}, 1);
   endtask

   task automatic sweep(input bit drop, input bit coll);
      drv(1'b0, coll, 3'd0, 3'd1, 4'hF, 32'h1234_5678, 1'b1);
      expect_at(2, 0, "sw_idle_busy", 0);
      for (int k = 1; k <= 8; k++) begin
         step();
         if (drop && k == 5) drv(1'b0, 1'b1, 3'd0, 3'd2, 4'hF, 32'hDEAD_BEEF, 1'b0);
         else                drv(1'b0, 1'b0, 3'd7, 3'd0, 4'h0, 32'h0, 1'b0);
         expect_at(2, 1, "sw_busy", 0);
         expect_at(3, 0, "sw_done_lo", 0);
         if (k == 1) expect_at(0, 0, "sw_busy_rd", 0);
      end
      step();
      drv(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 32'h0, 1'b0);
      expect_at(2, 0, "sw_end_busy", 0);
      expect_at(3, 1, "sw_done", 0);
      step();
      expect_at(3, 0, "sw_done_once", 0);
   endtask

   initial begin
      rst_n = 1'b1;
      drv(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      step();
      expect_at(0, 0, "rst_dout", 0);
      expect_at(1, 0, "rst_dout_r", 0);
      expect_at(2, 0, "rst_busy", 0);
      expect_at(3, 0, "rst_done", 0);
      step();
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         read_chk(3'(i), 32'h0, "t1_rd");
         step();
      end

      wr(3'd3, 4'hF, 32'hAABB_CCDD); step();
      wr(3'd3, 4'b0101, 32'h1122_3344); step();
      read_chk(3'd3, 32'hAA22_CC44, "t2_masked"); step();

      wr(3'd5, 4'hF, 32'hAA22_CC44); step();
      drv(1'b1, 1'b1, 3'd5, 3'd5, 4'b0001, 32'h0000_0099, 1'b0);
      expect_at(0, 32'hAA22_CC99, "t3_byp", 0);
      expect_at(1, 32'hAA22_CC99, "t3_byp_r", 1);
      step();
      read_chk(3'd5, 32'hAA22_CC99, "t3_stored"); step();
      wr(3'd5, 4'h0, 32'h0); step();
      read_chk(3'd5, 32'hAA22_CC99, "t3_nomask"); step();

      for (int i = 0; i < 8; i++) begin
         wr(3'(i), 4'hF, 32'hFFFF_FFFF);
         step();
      end
      sweep(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         read_chk(3'(i), 32'h0, "t4_clr");
         step();
      end

      sweep(1'b0, 1'b1);
      read_chk(3'd1, 32'h0, "t5_coll"); step();

      wr(3'd6, 4'hF, 32'h5A5A_5A5A); step();
      drv(1'b0, 1'b0, 3'd0, 3'd0, 4'h0, 32'h0, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         step();
         drv(1'b0, 1'b0, 3'd6, 3'd0, 4'h0, 32'h0, 1'b0);
         expect_at(2, 1, "t6_busy", 0);
      end
      step();
      rst_n = 1'b0;
      expect_at(2, 0, "t6_rst_busy", 0);
      expect_at(3, 0, "t6_rst_done", 0);
      expect_at(0, 0, "t6_rst_data", 0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         expect_at(3, 0, "t6_no_done", 0);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         read_chk(3'(i), 32'h0, "t6_rd");
         step();
      end
      sweep(1'b0, 1'b0);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors += sb.size();
         $display("FAIL unretired_expectations got=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/masked_array.md
# masked_array

Parametrised successor to the cache's flop-based set array: one entry per set, `2**s_index` sets, `width` bits each. Adds mask-granular partial writes, an optional registered-read mode, and a hardware clear sweep. Cache datapath and control use it for tag, valid, dirty, LRU and data storage. The cache controller starts a clear on flush/invalidate and stalls on `busy`.

## Interface
- `s_index`, default 3: index bits; `num_sets = 2**s_index`.
- `width`, default 32: entry width in bits.
- `gran`, default 8: bits per mask lane; `width` must be a multiple of `gran`; `nlanes = width/gran`.
- `reg_out`, default 0: 0 = combinational read; 1 = registered read, 1-cycle latency.
- `reset_val`, default 0: value loaded into every entry by reset and by clear.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `read` in 1: read enable; used only when `reg_out=1`.
- `load` in 1: write enable.
- `rindex` in `s_index`: read set.
- `windex` in `s_index`: write set.
- `wmask` in `nlanes`: lane `i` covers bits `[i*gran +: gran]`; a set bit writes that lane.
- `datain` in `width`: write data.
- `clear` in 1: start a clear sweep; single-cycle pulse or level.
- `busy` out 1: clear sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `dataout` out `width`: read data.

## Operation
- **Reset (`rst_n=0`, asynchronous):**
  - Every entry = `reset_val`.
  - FSM = IDLE; sweep counter = 0.
  - `busy=0`, `done=0`.
  - Registered `dataout` = `reset_val`. Combinational `dataout` = `reset_val`, since every entry holds it.
- **FSM states:**
  - IDLE: `clear=1` moves to SWEEP with counter 0.
  - SWEEP: each cycle writes `reset_val` to set `counter`, then increments the counter.
    - The cycle with `counter = num_sets-1` returns to IDLE and asserts `done` in the following cycle.
    - The counter is `s_index` bits wide and wraps to 0 on exit.
- **Writes:**
  - In IDLE, `load=1` updates only the lanes of `data[windex]` whose `wmask` bit is set.
  - `load` with `wmask=0` is a no-op.
  - In SWEEP, `load` is ignored and the write is dropped. The controller must hold its write until `busy=0`.
- **Simultaneous events:**
  - `clear` with `load` in IDLE: clear wins, the write is dropped.
  - `clear` during SWEEP is ignored; the sweep does not restart.
  - `clear` held high continuously re-arms after IDLE is reached. The next sweep starts in the cycle after `done`.
- **Read bypass (write-first):**
  - When `load`, `!busy` and `rindex==windex`, the read value is the merge: `datain` on masked lanes, stored data on the others.
  - Otherwise the read value is `data[rindex]`.
- **`reg_out=0`:** `dataout` is the read value, combinationally. It equals `reset_val` while `busy=1`.
- **`reg_out=1`:**
  - `read=1` at an edge captures the read value into `dataout`. The bypass merge is included.
  - `read=0` holds `dataout`.
  - While `busy=1`, a `read` captures `reset_val`.
- **Mid-sweep reset:** `rst_n` low aborts the sweep immediately. All state returns to reset values and no `done` pulse is issued.

## Timing
- `clear` sampled high in IDLE at edge E0: `busy=1` from E0 through edge E0+`num_sets`.
  - Set k is cleared at edge E0+1+k.
  - `done=1` for the cycle after edge E0+`num_sets`, with `busy=0` in the same cycle.
- Sweep length: exactly `num_sets` busy cycles (8 with defaults).
- Write latency: 1 edge. The write is visible to a same-cycle read through the bypass, and to a stored read from the next cycle.
- Read latency: 0 cycles (`reg_out=0`) or 1 cycle (`reg_out=1`).
- `busy` and `done` are registered outputs; neither has a combinational path from any input.

## Test plan
1. **Reset:** `rst_n=0` then 1, `reset_val=0`. Read all 8 sets → `dataout=0`, `busy=0`, `done=0`.
2. **Masked write:**
   - Step 1: write set 3 with `datain=0xAABBCCDD`, `wmask=4'b1111`.
   - Step 2: write set 3 with `datain=0x11223344`, `wmask=4'b0101`.
   - Read set 3 → `0xAA22CC44`.
3. **Bypass:** holding `0xAA22CC44` in set 5, drive `load=1`, `rindex=windex=5`, `datain=0x00000099`, `wmask=4'b0001`.
   - `reg_out=0`: same-cycle `dataout=0xAA22CC99`.
   - `reg_out=1`: `dataout=0xAA22CC99` after the edge.
4. **Clear sweep:**
   - Fill sets 0–7 with `0xFFFFFFFF`, pulse `clear` for one cycle.
   - `busy` is high for exactly 8 cycles, then `done` pulses once.
   - All sets read `reset_val`.
   - A `load` to set 2 issued while `busy=1` is dropped: set 2 still reads 0.
5. **Clear and write collide:** with `clear=1` and `load=1` to set 1 (`0x12345678`) in the same IDLE cycle, a sweep runs and set 1 reads 0 afterwards.
6. **Reset mid-sweep:** assert `rst_n=0` at sweep cycle 4.
   - Immediately: `busy=0`, no `done` pulse.
   - All sets read `reset_val`.
   - A new `clear` starts a full 8-cycle sweep.
